// File: rtl/dmem_pkg.sv
// dmem_pkg: types and constants shared by the data-memory access controller
// and the load sign/zero-extension stage.
//   dmem_state_t  : access controller FSM states (IDLE, REQ, DONE)
//   F3_*          : Funct3 size encodings for loads and stores
//   f3_is_load    : Funct3 code names a legal load size
//   f3_is_store   : Funct3 code names a legal store size
//   is_aligned    : byte offset is naturally aligned for the given size
package dmem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } dmem_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   function automatic logic f3_is_load(input logic [2:0] f3);
      logic ok;
      case (f3)
         F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
         default:                        ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Stores have no unsigned variants.
   function automatic logic f3_is_store(input logic [2:0] f3);
      logic ok;
      case (f3)
         F3_B, F3_H, F3_W: ok = 1'b1;
         default:          ok = 1'b0;
      endcase
      return ok;
   endfunction

   function automatic logic is_aligned(input logic [2:0] f3, input logic [1:0] lo);
      logic ok;
      case (f3)
         F3_B, F3_BU: ok = 1'b1;
         F3_H, F3_HU: ok = ~lo[0];
         F3_W:        ok = (lo == 2'b00);
         default:     ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/store_align.sv
// store_align: combinational store lane steering.
//   funct3    in  : access size code
//   addr_lo   in  : byte offset within the word
//   wdata     in  : right-aligned store data
//   be        out : byte enables for the addressed lanes
//   lane_data out : store data replicated so every lane carries the value
module store_align
   import dmem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] lane_data
);

   // Replication puts the value on every lane, so the byte enables alone
   // select where it lands; no offset-dependent data shifting is needed.
   always_comb begin
      be        = 4'b1111;
      lane_data = wdata;
      case (funct3)
         F3_B, F3_BU: begin
            be        = 4'b0001 << addr_lo;
            lane_data = {4{wdata[7:0]}};
         end
         F3_H, F3_HU: begin
            be        = 4'b0011 << addr_lo;
            lane_data = {2{wdata[15:0]}};
         end
         default: begin
            be        = 4'b1111;
            lane_data = wdata;
         end
      endcase
   end

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: Memory-stage data memory access controller.
// Turns a load/store in M into one bus transaction, stalling the pipeline
// until the bus completes, and flags misaligned or illegal accesses.
//   clk, reset              : clock, synchronous active-high reset
//   MemReadM, MemWriteM     : load / store strobes from M
//   Funct3M                 : access size code
//   ALUResultM, WriteDataM  : byte address, right-aligned store data
//   MemReq, MemWe, MemAddr,
//   MemBe, MemWData         : registered bus request (held through REQ)
//   MemReady, MemRData      : bus completion pulse and read data
//   ReadDataM               : completed load word shifted to byte 0
//   StallM                  : freeze pipeline up to and including M
//   AccessFaultM            : one-cycle fault pulse
//   state_dbg               : current FSM state (dmem_state_t encoding)
//
// Handshake: a request is outstanding while MemReq=1; the bus completes it
// with a single-cycle MemReady pulse, and MemReq drops on the next edge.
// MemReady outside an outstanding request is ignored.
module dmem_access_ctrl
   import dmem_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  MemReadM,
   input  logic                  MemWriteM,
   input  logic [2:0]            Funct3M,
   input  logic [ADDR_WIDTH-1:0] ALUResultM,
   input  logic [DATA_WIDTH-1:0] WriteDataM,
   output logic                  MemReq,
   output logic                  MemWe,
   output logic [ADDR_WIDTH-1:0] MemAddr,
   output logic [3:0]            MemBe,
   output logic [DATA_WIDTH-1:0] MemWData,
   input  logic                  MemReady,
   input  logic [DATA_WIDTH-1:0] MemRData,
   output logic [DATA_WIDTH-1:0] ReadDataM,
   output logic                  StallM,
   output logic                  AccessFaultM,
   output logic [1:0]            state_dbg
);

   dmem_state_t state, state_next;

   logic        one_strobe;
   logic        any_strobe;
   logic        size_ok;
   logic        access_ok;
   logic        access_bad;
   logic [3:0]  sa_be;
   logic [31:0] sa_data;

   // Captured at request time so the completion can shift the read word
   // without relying on M-stage inputs that may have changed.
   logic        load_pend;
   logic [1:0]  byte_off;

   assign one_strobe = MemReadM ^ MemWriteM;
   assign any_strobe = MemReadM | MemWriteM;
   assign size_ok    = MemWriteM ? f3_is_store(Funct3M) : f3_is_load(Funct3M);
   assign access_ok  = one_strobe && size_ok && is_aligned(Funct3M, ALUResultM[1:0]);
   assign access_bad = any_strobe && !access_ok;
   assign state_dbg  = state;

   store_align u_store_align (
      .funct3    (Funct3M),
      .addr_lo   (ALUResultM[1:0]),
      .wdata     (WriteDataM),
      .be        (sa_be),
      .lane_data (sa_data)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next   = state;
      StallM       = 1'b0;
      AccessFaultM = 1'b0;
      case (state)
         ST_IDLE: begin
            if (access_ok) begin
               StallM     = 1'b1;
               state_next = ST_REQ;
            end else if (access_bad) begin
               AccessFaultM = 1'b1;
            end
         end
         ST_REQ: begin
            StallM = 1'b1;
            if (MemReady) state_next = ST_DONE;
         end
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
      // Reset overrides everything so a half-decoded access cannot leak out.
      if (reset) begin
         StallM       = 1'b0;
         AccessFaultM = 1'b0;
         state_next   = ST_IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         MemReq    <= 1'b0;
         MemWe     <= 1'b0;
         MemAddr   <= '0;
         MemBe     <= 4'b0000;
         MemWData  <= '0;
         ReadDataM <= '0;
         load_pend <= 1'b0;
         byte_off  <= 2'b00;
      end else begin
         case (state)
            ST_IDLE: begin
               if (access_ok) begin
                  MemReq    <= 1'b1;
                  MemWe     <= MemWriteM;
                  MemAddr   <= {ALUResultM[ADDR_WIDTH-1:2], 2'b00};
                  MemBe     <= MemWriteM ? sa_be : 4'b1111;
                  MemWData  <= MemWriteM ? sa_data : '0;
                  load_pend <= MemReadM;
                  byte_off  <= ALUResultM[1:0];
               end
            end
            ST_REQ: begin
               if (MemReady) begin
                  MemReq <= 1'b0;
                  MemWe  <= 1'b0;
                  if (load_pend) ReadDataM <= MemRData >> {byte_off, 3'b000};
               end
            end
            default: ;
         endcase
      end
   end

endmodule
